// File: rtl/digit_window_scroller_if.sv
// Bus bundle for digit_window_scroller: source digits and controls in, windowed display digits out.
interface digit_window_scroller_if #(
  parameter int unsigned IN_SIZE   = 17,
  parameter int unsigned OUT_SIZE  = 6,
  parameter int unsigned DIG_WIDTH = 4
);
  localparam int unsigned SHIFT_AMT_SIZE = $clog2(IN_SIZE - OUT_SIZE + 1);

  logic [IN_SIZE-1:0][DIG_WIDTH-1:0]  in_digits;
  logic                               mode_auto;
  logic                               scroll_up;
  logic                               scroll_down;
  logic [SHIFT_AMT_SIZE-1:0]          shift_amount;
  logic [OUT_SIZE-1:0][DIG_WIDTH-1:0] out_digits;
  logic [OUT_SIZE-1:0]                blank_mask;
  logic                               at_min;
  logic                               at_max;

  modport master (
    output in_digits, mode_auto, scroll_up, scroll_down,
    input  shift_amount, out_digits, blank_mask, at_min, at_max
  );

  modport slave (
    input  in_digits, mode_auto, scroll_up, scroll_down,
    output shift_amount, out_digits, blank_mask, at_min, at_max
  );
endinterface

// File: rtl/digit_window_scroller.sv
// Selects an OUT_SIZE-digit window from a BCD value, scrolled manually or auto-ranged with
// hysteresis on shrink, and produces a leading-zero blanking mask. All outputs are registered.
module digit_window_scroller #(
  parameter int unsigned IN_SIZE     = 17,
  parameter int unsigned OUT_SIZE    = 6,
  parameter int unsigned DIG_WIDTH   = 4,
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input logic                     clk,
  input logic                     rst,
  digit_window_scroller_if.slave  bus
);
  localparam int unsigned MAX_SHIFT      = IN_SIZE - OUT_SIZE;
  localparam int unsigned SHIFT_AMT_SIZE = $clog2(MAX_SHIFT + 1);
  localparam int unsigned HOLD_W         = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [OUT_SIZE-1:0] BlankRst = {{(OUT_SIZE-1){1'b1}}, 1'b0};

  logic [SHIFT_AMT_SIZE-1:0]          shift_q, shift_d;
  logic [HOLD_W-1:0]                  hold_q, hold_d;
  logic [OUT_SIZE-1:0][DIG_WIDTH-1:0] out_q, out_d;
  logic [OUT_SIZE-1:0]                blank_q, blank_d;
  logic                               at_min_q, at_min_d;
  logic                               at_max_q, at_max_d;

  int unsigned msd;
  int unsigned target;
  logic        any_nz;

  always_comb begin
    msd    = 0;
    any_nz = 1'b0;
    for (int unsigned k = 0; k < IN_SIZE; k++) begin
      if (bus.in_digits[k] != '0) begin
        msd    = k;
        any_nz = 1'b1;
      end
    end
    // Guarded subtraction: small msd maps to base 0 instead of wrapping.
    if (msd < OUT_SIZE - 1) begin
      target = 0;
    end else if (msd - (OUT_SIZE - 1) > MAX_SHIFT) begin
      target = MAX_SHIFT;
    end else begin
      target = msd - (OUT_SIZE - 1);
    end
  end

  always_comb begin
    shift_d = shift_q;
    hold_d  = '0;
    if (!bus.mode_auto) begin
      if (bus.scroll_up && !bus.scroll_down && shift_q != SHIFT_AMT_SIZE'(MAX_SHIFT)) begin
        shift_d = shift_q + 1'b1;
      end else if (bus.scroll_down && !bus.scroll_up && shift_q != '0) begin
        shift_d = shift_q - 1'b1;
      end
    end else if (target > 32'(shift_q)) begin
      shift_d = SHIFT_AMT_SIZE'(target);
    end else if (target < 32'(shift_q)) begin
      // Shrink only after the smaller target has persisted for HOLD_CYCLES cycles.
      if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
        shift_d = SHIFT_AMT_SIZE'(target);
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_comb begin
    out_d   = '0;
    blank_d = '0;
    for (int unsigned i = 0; i < OUT_SIZE; i++) begin
      int unsigned idx;
      idx = 32'(shift_d) + i;
      if (idx < IN_SIZE) begin
        out_d[i] = bus.in_digits[idx];
      end
      // Digit is a leading zero when nothing at or above its source index is nonzero.
      blank_d[i] = (i != 0) && (!any_nz || idx > msd);
    end
    at_min_d = (shift_d == '0);
    at_max_d = (shift_d == SHIFT_AMT_SIZE'(MAX_SHIFT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '0;
      hold_q   <= '0;
      out_q    <= '0;
      blank_q  <= BlankRst;
      at_min_q <= 1'b1;
      at_max_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      hold_q   <= hold_d;
      out_q    <= out_d;
      blank_q  <= blank_d;
      at_min_q <= at_min_d;
      at_max_q <= at_max_d;
    end
  end

  assign bus.shift_amount = shift_q;
  assign bus.out_digits   = out_q;
  assign bus.blank_mask   = blank_q;
  assign bus.at_min       = at_min_q;
  assign bus.at_max       = at_max_q;
endmodule

// File: tb/tb_digit_window_scroller.sv
// Scoreboard bench for digit_window_scroller with HOLD_CYCLES=4: directed vectors push expected
// outputs into a queue; a monitor pops and compares after every clock edge.
module tb_digit_window_scroller;
  localparam int unsigned IN_SIZE   = 17;
  localparam int unsigned OUT_SIZE  = 6;
  localparam int unsigned DIG_WIDTH = 4;
  localparam int unsigned HOLD      = 4;

  typedef logic [IN_SIZE-1:0][DIG_WIDTH-1:0]  din_t;
  typedef logic [OUT_SIZE-1:0][DIG_WIDTH-1:0] dout_t;

  typedef struct {
    logic [3:0] shift;
    dout_t      digits;
    logic [5:0] blank;
    logic       amin;
    logic       amax;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  digit_window_scroller_if #(
    .IN_SIZE  (IN_SIZE),
    .OUT_SIZE (OUT_SIZE),
    .DIG_WIDTH(DIG_WIDTH)
  ) dif ();

  digit_window_scroller #(
    .IN_SIZE    (IN_SIZE),
    .OUT_SIZE   (OUT_SIZE),
    .DIG_WIDTH  (DIG_WIDTH),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic din_t dig(input int idx, input logic [3:0] v);
    din_t d;
    d = '0;
    d[idx] = v;
    return d;
  endfunction

  function automatic dout_t window(input din_t d, input int s);
    dout_t w;
    for (int i = 0; i < OUT_SIZE; i++) w[i] = d[s + i];
    return w;
  endfunction

  task automatic step(input logic r, input logic m, input logic up, input logic dn,
                      input din_t d, input int es, input logic [5:0] eb);
    exp_t e;
    @(negedge clk);
    rst               = r;
    dif.mode_auto     = m;
    dif.scroll_up     = up;
    dif.scroll_down   = dn;
    dif.in_digits     = d;
    e.shift  = 4'(es);
    e.digits = r ? dout_t'(0) : window(d, es);
    e.blank  = eb;
    e.amin   = (es == 0);
    e.amax   = (es == 11);
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are registered, so every edge presents one result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("shift_amount", 32'(dif.shift_amount), 32'(e.shift));
        chk("out_digits", 32'(dif.out_digits), 32'(e.digits));
        chk("blank_mask", 32'(dif.blank_mask), 32'(e.blank));
        chk("at_min", 32'(dif.at_min), 32'(e.amin));
        chk("at_max", 32'(dif.at_max), 32'(e.amax));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    din_t pat;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    dif.mode_auto   = 1'b0;
    dif.scroll_up   = 1'b0;
    dif.scroll_down = 1'b0;
    dif.in_digits   = '0;

    // Reset, including nonzero inputs while held in reset.
    step(1, 0, 0, 0, '0, 0, 6'b111110);
    step(1, 0, 0, 0, dig(0, 9), 0, 6'b111110);
    step(0, 0, 0, 0, '0, 0, 6'b111110);

    // Manual scrolling; digit 16 nonzero keeps every window unblanked.
    pat = dig(16, 1) | dig(3, 2) | dig(8, 5);
    for (int k = 1; k <= 12; k++) step(0, 0, 1, 0, pat, (k > 11) ? 11 : k, 6'b000000);
    step(0, 0, 1, 1, pat, 11, 6'b000000);
    for (int k = 1; k <= 12; k++) step(0, 0, 0, 1, pat, (11 - k < 0) ? 0 : 11 - k, 6'b000000);
    step(0, 0, 0, 1, '0, 0, 6'b111110);

    // Auto mode ignores scroll inputs; growth lands one cycle later.
    step(0, 1, 1, 0, '0, 0, 6'b111110);
    step(0, 1, 0, 0, dig(9, 7), 4, 6'b000000);
    step(0, 1, 0, 0, dig(9, 7), 4, 6'b000000);

    // Shrink after HOLD cycles of smaller target.
    step(0, 1, 0, 0, '0, 4, 6'b111110);
    step(0, 1, 0, 0, '0, 4, 6'b111110);
    step(0, 1, 0, 0, '0, 4, 6'b111110);
    step(0, 1, 0, 0, '0, 0, 6'b111110);

    // Glitch restores digit 9 mid-hold; window never drops.
    step(0, 1, 0, 0, dig(9, 7), 4, 6'b000000);
    step(0, 1, 0, 0, '0, 4, 6'b111110);
    step(0, 1, 0, 0, '0, 4, 6'b111110);
    step(0, 1, 0, 0, dig(9, 7), 4, 6'b000000);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, '0, 4, 6'b111110);
    step(0, 1, 0, 0, dig(9, 7), 4, 6'b000000);

    // Mode switches: auto->manual keeps shift, manual->auto shrinks after a full hold.
    step(0, 0, 0, 0, dig(9, 7), 4, 6'b000000);
    step(0, 0, 0, 1, dig(9, 7), 3, 6'b000000);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, dig(2, 5), 3, 6'b111110);
    step(0, 1, 0, 0, dig(2, 5), 0, 6'b111000);

    // Reset while hold_cnt=2 at shift 7.
    step(0, 1, 0, 0, dig(12, 3), 7, 6'b000000);
    step(0, 1, 0, 0, '0, 7, 6'b111110);
    step(0, 1, 0, 0, '0, 7, 6'b111110);
    step(1, 1, 0, 0, '0, 0, 6'b111110);
    step(0, 1, 0, 0, dig(12, 3), 7, 6'b000000);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, '0, 7, 6'b111110);
    step(0, 1, 0, 0, '0, 0, 6'b111110);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
